alu_op_issuer: RTL and testbench

Instruction-driven initiator for the team's combinational 8-bit ALU (a, b, sel → 9-bit result). Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 4×8 register file. Drives the ALU operand/opcode ports from registers, captures the 9-bit result one cycle later, writes it back, and presents data plus carry/zero flags on a valid/ready response port.

---
 rtl/alu_issuer_pkg.sv | 41 ++++
 rtl/alu_op_issuer_if.sv | 26 ++
 rtl/regfile_4x8.sv | 30 +++
 rtl/alu_op_issuer.sv | 126 ++++++++++++
 tb/tb_alu_op_issuer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/alu_issuer_pkg.sv
// Shared definitions for the ALU op issuer: opcodes, FSM states and instruction field positions.
package alu_issuer_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam int LI_BIT   = 15;
  localparam int LI_RD_HI = 14;
  localparam int LI_RD_LO = 13;
  localparam int IMM_HI   = 7;
  localparam int IMM_LO   = 0;
  localparam int OP_HI    = 14;
  localparam int OP_LO    = 12;
  localparam int RD_HI    = 11;
  localparam int RD_LO    = 10;
  localparam int RA_HI    = 9;
  localparam int RA_LO    = 8;
  localparam int RB_HI    = 7;
  localparam int RB_LO    = 6;

  // Only arithmetic ops report bit 8; logic ops (NOT included) force carry low.
  function automatic logic op_has_carry(input logic [2:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_INC, OP_DEC: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_issuer_if.sv
// Instruction, ALU and response signal bundle between the issuer and its environment.
interface alu_op_issuer_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [8:0]  alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_carry;
  logic        out_zero;
  logic [1:0]  out_rd;

  modport master (
    input  in_valid, instr, alu_result, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_carry, out_zero, out_rd
  );

  modport slave (
    output in_valid, instr, alu_result, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_carry, out_zero, out_rd
  );
endinterface

// File: rtl/regfile_4x8.sv
// Four 8-bit registers: two asynchronous read ports, one synchronous write port, async clear.
module regfile_4x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] rd_addr_a,
  input  logic [1:0] rd_addr_b,
  output logic [7:0] rd_data_a,
  output logic [7:0] rd_data_b,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [7:0] wr_data
);

  logic [7:0] regs_r [4];

  assign rd_data_a = regs_r[rd_addr_a];
  assign rd_data_b = regs_r[rd_addr_b];

  // Register storage with clear on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (wr_en) begin
      regs_r[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/alu_op_issuer.sv
// Issues one instruction at a time to an external combinational ALU and reports the
// written-back value with carry/zero flags over a valid/ready response port.
module alu_op_issuer
  import alu_issuer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  alu_op_issuer_if.master bus
);

  state_t     state_r, state_s;
  logic [1:0] rd_r;
  logic [7:0] alu_a_r, alu_b_r;
  logic [2:0] alu_sel_r;
  logic [7:0] out_data_r;
  logic       out_carry_r, out_zero_r;
  logic [1:0] out_rd_r;

  logic       accept_s, is_li_s;
  logic       we_s, carry_s;
  logic [1:0] wa_s;
  logic [7:0] wd_s;
  logic [7:0] ra_data_s, rb_data_s;
  logic       unused_bits_s;

  assign unused_bits_s = ^bus.instr[5:0];
  assign accept_s      = bus.in_valid && (state_r == IDLE);
  assign is_li_s       = bus.instr[LI_BIT];

  regfile_4x8 u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (bus.instr[RA_HI:RA_LO]),
    .rd_addr_b (bus.instr[RB_HI:RB_LO]),
    .rd_data_a (ra_data_s),
    .rd_data_b (rb_data_s),
    .wr_en     (we_s),
    .wr_addr   (wa_s),
    .wr_data   (wd_s)
  );

  // Next state and writeback selection; LI writes at accept, ALU ops at the EXEC edge
  always_comb begin
    state_s = state_r;
    we_s    = 1'b0;
    wa_s    = rd_r;
    wd_s    = bus.alu_result[7:0];
    carry_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (is_li_s) begin
            state_s = RESP;
            we_s    = 1'b1;
            wa_s    = bus.instr[LI_RD_HI:LI_RD_LO];
            wd_s    = bus.instr[IMM_HI:IMM_LO];
          end else begin
            state_s = EXEC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      EXEC: begin
        state_s = RESP;
        we_s    = 1'b1;
        carry_s = op_has_carry(alu_sel_r) ? bus.alu_result[8] : 1'b0;
      end
      RESP: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // ALU operand/opcode registers; they hold their value outside an ALU issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r   <= 8'h00;
      alu_b_r   <= 8'h00;
      alu_sel_r <= 3'b000;
      rd_r      <= 2'b00;
    end else if (accept_s && !is_li_s) begin
      alu_a_r   <= ra_data_s;
      alu_b_r   <= rb_data_s;
      alu_sel_r <= bus.instr[OP_HI:OP_LO];
      rd_r      <= bus.instr[RD_HI:RD_LO];
    end
  end

  // Response capture; only a writeback updates it, so it holds under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= 8'h00;
      out_carry_r <= 1'b0;
      out_zero_r  <= 1'b0;
      out_rd_r    <= 2'b00;
    end else if (we_s) begin
      out_data_r  <= wd_s;
      out_carry_r <= carry_s;
      out_zero_r  <= (wd_s == 8'h00);
      out_rd_r    <= wa_s;
    end
  end

  assign bus.in_ready  = (state_r == IDLE);
  assign bus.out_valid = (state_r == RESP);
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_sel   = alu_sel_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_carry = out_carry_r;
  assign bus.out_zero  = out_zero_r;
  assign bus.out_rd    = out_rd_r;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench: issuer plus a behavioural 8-bit ALU, checked with immediate assertions.
module tb_alu_op_issuer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_op_issuer_if bus ();

  alu_op_issuer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // The team ALU: a, b, sel -> 9-bit result
  always_comb begin
    case (bus.alu_sel)
      3'b000:  bus.alu_result = {1'b0, bus.alu_a & bus.alu_b};
      3'b001:  bus.alu_result = {1'b0, bus.alu_a | bus.alu_b};
      3'b010:  bus.alu_result = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b011:  bus.alu_result = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'b100:  bus.alu_result = {1'b0, bus.alu_a ^ bus.alu_b};
      3'b101:  bus.alu_result = ~{1'b0, bus.alu_a};
      3'b110:  bus.alu_result = {1'b0, bus.alu_a} + 9'd1;
      3'b111:  bus.alu_result = {1'b0, bus.alu_a} - 9'd1;
      default: bus.alu_result = 9'h000;
    endcase
  end

  function automatic logic [15:0] li(input logic [1:0] rd, input logic [7:0] imm);
    return {1'b1, rd, 5'b00000, imm};
  endfunction

  function automatic logic [15:0] aop(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb);
    return {1'b0, op, rd, ra, rb, 6'b000000};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an instruction and return just after the edge that accepts it
  task automatic issue(input logic [15:0] w);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.instr    = w;
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    chk("issue_ready", 16'(bus.in_ready), 16'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_alu(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] sel);
    chk({tag, "_alu_a"}, 16'(bus.alu_a), 16'(a));
    chk({tag, "_alu_b"}, 16'(bus.alu_b), 16'(b));
    chk({tag, "_alu_sel"}, 16'(bus.alu_sel), 16'(sel));
  endtask

  // Wait (bounded) for the response, check it, and complete the handshake
  task automatic resp(input string tag, input logic [7:0] d, input logic c, input logic z,
                      input logic [1:0] rd);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk({tag, "_valid"}, 16'(bus.out_valid), 16'd1);
    chk({tag, "_data"}, 16'(bus.out_data), 16'(d));
    chk({tag, "_carry"}, 16'(bus.out_carry), 16'(c));
    chk({tag, "_zero"}, 16'(bus.out_zero), 16'(z));
    chk({tag, "_rd"}, 16'(bus.out_rd), 16'(rd));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = 16'h0000;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    check_alu("rst", 8'h00, 8'h00, 3'b000);
    chk("rst_out_data", 16'(bus.out_data), 16'h0000);
    chk("rst_out_carry", 16'(bus.out_carry), 16'd0);
    chk("rst_out_zero", 16'(bus.out_zero), 16'd0);
    chk("rst_out_rd", 16'(bus.out_rd), 16'd0);

    issue(li(2'd1, 8'hF0)); resp("li_r1", 8'hF0, 1'b0, 1'b0, 2'd1);
    issue(li(2'd2, 8'h0F)); resp("li_r2", 8'h0F, 1'b0, 1'b0, 2'd2);
    issue(aop(3'b010, 2'd3, 2'd1, 2'd2));
    check_alu("add", 8'hF0, 8'h0F, 3'b010);
    resp("add", 8'hFF, 1'b0, 1'b0, 2'd3);

    issue(li(2'd0, 8'hFF)); resp("li_r0", 8'hFF, 1'b0, 1'b0, 2'd0);
    issue(aop(3'b110, 2'd0, 2'd0, 2'd0)); resp("inc", 8'h00, 1'b1, 1'b1, 2'd0);
    issue(aop(3'b111, 2'd0, 2'd0, 2'd0)); resp("dec", 8'hFF, 1'b1, 1'b0, 2'd0);

    issue(li(2'd1, 8'h05)); resp("li_r1b", 8'h05, 1'b0, 1'b0, 2'd1);
    issue(li(2'd2, 8'h07)); resp("li_r2b", 8'h07, 1'b0, 1'b0, 2'd2);
    issue(aop(3'b011, 2'd3, 2'd1, 2'd2)); resp("sub", 8'hFE, 1'b1, 1'b0, 2'd3);
    issue(li(2'd1, 8'h0F)); resp("li_r1c", 8'h0F, 1'b0, 1'b0, 2'd1);
    issue(aop(3'b101, 2'd2, 2'd1, 2'd3));
    check_alu("not", 8'h0F, 8'hFE, 3'b101);
    resp("not", 8'hF0, 1'b0, 1'b0, 2'd2);

    // Backpressure: response must hold while a new instruction waits
    bus.out_ready = 1'b0;
    issue(li(2'd0, 8'h5A));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.instr    = li(2'd1, 8'h33);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 16'(bus.out_valid), 16'd1);
      chk("bp_data", 16'(bus.out_data), 16'h005A);
      chk("bp_in_ready", 16'(bus.in_ready), 16'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", 16'(bus.out_valid), 16'd0);
    chk("bp_hs_in_ready", 16'(bus.in_ready), 16'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("bp_next_valid", 16'(bus.out_valid), 16'd1);
    chk("bp_next_data", 16'(bus.out_data), 16'h0033);
    chk("bp_next_rd", 16'(bus.out_rd), 16'd1);
    @(posedge clk);
    #1;

    // Reset during EXEC of ADD r3: no response, registers cleared
    issue(aop(3'b010, 2'd3, 2'd1, 2'd2));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(bus.out_valid), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", 16'(bus.out_valid), 16'd0);
    end
    chk("mid_rst_data", 16'(bus.out_data), 16'h0000);
    issue(aop(3'b001, 2'd0, 2'd3, 2'd3));
    check_alu("read_r3", 8'h00, 8'h00, 3'b001);
    resp("read_r3", 8'h00, 1'b0, 1'b1, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
